// File: rtl/arm_pkg.sv
// Shared fetch-stage definitions: fetch FSM encoding, IF/ID bubble word and PC step.
package arm_pkg;

  localparam logic [1:0] ST_REQ     = 2'd0;
  localparam logic [1:0] ST_DISCARD = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

  // cond field = NV, so the decode stage zeroes all controls for this word
  localparam logic [31:0] IF_BUBBLE = 32'hF000_0000;

  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush (to bubble) wins over load; otherwise holds its contents.
module if_id_reg
  import arm_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              flush,
  input  logic [31:0]       instr_in,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] pc,
  output logic              valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr <= IF_BUBBLE;
      pc    <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= IF_BUBBLE;
      pc    <= '0;
      valid <= 1'b0;
    end else if (load) begin
      instr <= instr_in;
      pc    <= pc_in;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC, imem req/ready FSM (REQ/DISCARD/HOLD) and built-in IF/ID register.
// Optional IF_PERF_CNT_EN adds fetch_cnt / stall_cnt performance counters.
module if_fetch_stage
  import arm_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              Branch_taken,
  input  logic [ADDR_W-1:0] BranchAddr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       Instruction,
  output logic [ADDR_W-1:0] PC,
  output logic              if_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [31:0]       hold_instr_q, hold_instr_d;
  logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;

  logic [ADDR_W-1:0] branch_tgt;
  logic [ADDR_W-1:0] req_next;
  logic              enter_req;
  logic              ifid_load;
  logic              ifid_flush;
  logic [31:0]       ifid_instr_in;
  logic [ADDR_W-1:0] ifid_pc_in;
  logic              unused_branch_lsbs;

  assign branch_tgt         = {BranchAddr[ADDR_W-1:2], 2'b00};
  assign unused_branch_lsbs = ^BranchAddr[1:0];
  assign req_next           = req_addr_q + ADDR_W'(PC_INC);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_addr_d    = req_addr_q;
    hold_instr_d  = hold_instr_q;
    hold_pc_d     = hold_pc_q;
    enter_req     = 1'b0;
    ifid_load     = 1'b0;
    ifid_flush    = 1'b0;
    ifid_instr_in = imem_rdata;
    ifid_pc_in    = req_next;

    case (state_q)
      ST_REQ: begin
        if (Branch_taken) begin
          pc_d       = branch_tgt;
          ifid_flush = 1'b1;
          if (imem_ready) begin
            enter_req = 1'b1;
          end else begin
            state_d = ST_DISCARD;
          end
        end else if (imem_ready) begin
          pc_d = req_next;
          if (freeze) begin
            hold_instr_d = imem_rdata;
            hold_pc_d    = req_next;
            state_d      = ST_HOLD;
          end else begin
            ifid_load = 1'b1;
            enter_req = 1'b1;
          end
        end else if (!freeze) begin
          ifid_flush = 1'b1;
        end
      end

      // Wrong-path request still in flight: let it complete, then drop its data
      ST_DISCARD: begin
        if (Branch_taken) begin
          pc_d       = branch_tgt;
          ifid_flush = 1'b1;
        end else if (!freeze) begin
          ifid_flush = 1'b1;
        end
        if (imem_ready) begin
          enter_req = 1'b1;
        end
      end

      ST_HOLD: begin
        if (Branch_taken) begin
          pc_d       = branch_tgt;
          ifid_flush = 1'b1;
          enter_req  = 1'b1;
        end else if (!freeze) begin
          ifid_load     = 1'b1;
          ifid_instr_in = hold_instr_q;
          ifid_pc_in    = hold_pc_q;
          enter_req     = 1'b1;
        end
      end

      default: begin
        enter_req = 1'b1;
      end
    endcase

    // The address is latched only when a new request starts, so it stays stable while pending
    if (enter_req) begin
      state_d    = ST_REQ;
      req_addr_d = pc_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_REQ;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      hold_instr_q <= IF_BUBBLE;
      hold_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

  assign imem_req  = ~rst & (state_q != ST_HOLD);
  assign imem_addr = req_addr_q;

  if_id_reg #(
    .ADDR_W(ADDR_W)
  ) u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (ifid_load),
    .flush   (ifid_flush),
    .instr_in(ifid_instr_in),
    .pc_in   (ifid_pc_in),
    .instr   (Instruction),
    .pc      (PC),
    .valid   (if_valid)
  );

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (ifid_load) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (freeze && if_valid) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: directed imem/freeze/branch vectors push expected IF/ID
// entries; a monitor pops and compares each freshly loaded IF/ID entry.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        Branch_taken;
  logic [31:0] BranchAddr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] Instruction;
  logic [31:0] PC;
  logic        if_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  if_fetch_stage #(
    .ADDR_W  (32),
    .RESET_PC(32'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .Branch_taken(Branch_taken),
    .BranchAddr  (BranchAddr),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .Instruction (Instruction),
    .PC          (PC),
    .if_valid    (if_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  localparam logic [31:0] BUBBLE = 32'hF000_0000;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ifid_t;

  ifid_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    ifid_t e;
    e.instr = instr;
    e.pc    = pc;
    exp_q.push_back(e);
  endtask

  // Apply one cycle of inputs; returns at the next falling edge with outputs settled
  task automatic cyc(input logic rdy, input logic [31:0] rd, input logic frz, input logic br,
                     input logic [31:0] ba);
    imem_ready   = rdy;
    imem_rdata   = rd;
    freeze       = frz;
    Branch_taken = br;
    BranchAddr   = ba;
    @(negedge clk);
  endtask

  // Monitor: IF/ID valid after an unfrozen edge means a newly loaded entry
  initial begin
    logic  f, r;
    ifid_t e;
    forever begin
      @(posedge clk);
      f = freeze;
      r = rst;
      #1;
      if (!r && !f && if_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_load: got instr %h pc %h, expected none", Instruction, PC);
        end else begin
          e = exp_q.pop_front();
          chk("ifid_instr", Instruction, e.instr);
          chk("ifid_pc", PC, e.pc);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_instr", Instruction, BUBBLE);
    chk("rst_pc", PC, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    rst = 1'b0;
    #1;
    chk("req_after_rst", {31'd0, imem_req}, 32'd1);
    chk("addr_after_rst", imem_addr, 32'h0);

    // Back-to-back fetches with ready every cycle
    push(32'hA000_0000, 32'd4);
    cyc(1'b1, 32'hA000_0000, 1'b0, 1'b0, 32'h0);
    chk("addr_seq1", imem_addr, 32'd4);
    push(32'hA000_0001, 32'd8);
    cyc(1'b1, 32'hA000_0001, 1'b0, 1'b0, 32'h0);
    chk("addr_seq2", imem_addr, 32'd8);
    push(32'hA000_0002, 32'd12);
    cyc(1'b1, 32'hA000_0002, 1'b0, 1'b0, 32'h0);
    chk("addr_seq3", imem_addr, 32'd12);

    // Memory 3 cycles late: address stable, bubbles into IF/ID
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk("late_addr", imem_addr, 32'd12);
      chk("late_req", {31'd0, imem_req}, 32'd1);
      chk("late_bubble", Instruction, BUBBLE);
      chk("late_valid", {31'd0, if_valid}, 32'd0);
    end
    push(32'hA000_0003, 32'd16);
    cyc(1'b1, 32'hA000_0003, 1'b0, 1'b0, 32'h0);
    chk("addr_after_late", imem_addr, 32'd16);

    // Freeze as data returns: HOLD, no request, IF/ID keeps old entry
    cyc(1'b1, 32'hE3A0_1005, 1'b1, 1'b0, 32'h0);
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    chk("hold_instr_kept", Instruction, 32'hA000_0003);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("hold_req2", {31'd0, imem_req}, 32'd0);
    chk("hold_pc_kept", PC, 32'd16);
    push(32'hE3A0_1005, 32'd20);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("post_hold_addr", imem_addr, 32'd20);
    chk("post_hold_req", {31'd0, imem_req}, 32'd1);

    // Branch mid-wait: DISCARD keeps old address, its data is dropped
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0043);
    chk("discard_addr", imem_addr, 32'd20);
    chk("discard_req", {31'd0, imem_req}, 32'd1);
    chk("discard_valid", {31'd0, if_valid}, 32'd0);
    cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    chk("redirect_addr", imem_addr, 32'h40);
    chk("dropped_valid", {31'd0, if_valid}, 32'd0);
    push(32'hB000_0000, 32'h44);
    cyc(1'b1, 32'hB000_0000, 1'b0, 1'b0, 32'h0);

    // Branch together with freeze while IF/ID valid: flush wins
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 32'h80);
    chk("brfrz_valid", {31'd0, if_valid}, 32'd0);
    chk("brfrz_instr", Instruction, BUBBLE);
    chk("brfrz_addr", imem_addr, 32'h44);
    cyc(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
    chk("brfrz_redirect", imem_addr, 32'h80);
    push(32'hC000_0000, 32'h84);
    cyc(1'b1, 32'hC000_0000, 1'b0, 1'b0, 32'h0);

    // Branch with ready in REQ, then PC wrap at the top of the address space
    cyc(1'b1, 32'h5555_5555, 1'b0, 1'b1, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk("br_ready_flush", {31'd0, if_valid}, 32'd0);
    push(32'hD000_0000, 32'h0);
    cyc(1'b1, 32'hD000_0000, 1'b0, 1'b0, 32'h0);
    chk("wrapped_addr", imem_addr, 32'h0);

    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

`ifdef IF_PERF_CNT_EN
    chk("fetch_cnt", fetch_cnt, 32'd8);
    chk("stall_cnt", stall_cnt, 32'd3);
    rst = 1'b1;
    #1;
    chk("fetch_cnt_rst", fetch_cnt, 32'd0);
    chk("stall_cnt_rst", stall_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
